// File: rtl/axi_llc_repl_unit.sv
// rtl/axi_llc_repl_unit.sv - LLC way replacement unit: tree-PLRU, LFSR random or round-robin with lock masking
// Build option: define AXI_LLC_REPL_STATS_EN to enable the saturating hit/miss/evict statistics counters.
module axi_llc_repl_unit #(
    parameter int unsigned NumWays    = 8,
    parameter int unsigned NumSets    = 256,
    parameter int unsigned ReplPolicy = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [$clog2(NumSets)-1:0] req_index_i,
    input  logic                       req_hit_i,
    input  logic [NumWays-1:0]         req_hit_way_i,
    input  logic [NumWays-1:0]         tag_valid_i,
    input  logic [NumWays-1:0]         tag_dirty_i,
    input  logic [NumWays-1:0]         lock_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [NumWays-1:0]         res_way_o,
    output logic                       res_evict_o,
    output logic                       res_no_way_o,
    output logic                       init_busy_o,
    output logic [31:0]                stat_hit_o,
    output logic [31:0]                stat_miss_o,
    output logic [31:0]                stat_evict_o
);

    localparam int unsigned WayW  = $clog2(NumWays);
    localparam int unsigned IdxW  = $clog2(NumSets);
    localparam int unsigned TreeW = NumWays - 1;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    if (ReplPolicy > 2 || NumWays < 2 || (NumWays & (NumWays - 1)) != 0 || NumSets < 2) begin : g_param_err
        $error("axi_llc_repl_unit: unsupported NumWays/NumSets/ReplPolicy");
    end

    logic [1:0]         state_q;
    logic [IdxW-1:0]    init_cnt_q;
    logic               in_init;
    logic               init_last;
    logic               accept;

    logic [NumWays-1:0] res_way_q;
    logic               res_evict_q;
    logic               res_no_way_q;

    logic [WayW-1:0]    pol_victim;
    logic [WayW-1:0]    free_idx;
    logic [WayW-1:0]    unl_idx;
    logic [WayW-1:0]    hit_idx;
    logic               has_free;
    logic               all_locked;
    logic [WayW-1:0]    miss_way;
    logic [WayW-1:0]    upd_way;
    logic [NumWays-1:0] sel_way;
    logic               sel_evict;
    logic               sel_noway;

    // Walk the tree from the root; a 0 bit steers to the lower-index child
    function automatic logic [WayW-1:0] plru_victim(input logic [TreeW-1:0] bits);
        int unsigned      node;
        logic [TreeW-1:0] sh;
        node = 0;
        for (int unsigned lvl = 0; lvl < WayW; lvl++) begin
            sh   = bits >> node;
            node = 2 * node + (sh[0] ? 32'd2 : 32'd1);
        end
        return WayW'(node - TreeW);
    endfunction

    // Rewrite every node on the path to way so it points at the opposite subtree
    function automatic logic [TreeW-1:0] plru_touch(input logic [TreeW-1:0] bits, input logic [WayW-1:0] way);
        logic [TreeW-1:0] res;
        logic [WayW-1:0]  wsh;
        logic             dir;
        int unsigned      node;
        res  = bits;
        node = 0;
        for (int unsigned lvl = 0; lvl < WayW; lvl++) begin
            wsh  = way >> (WayW - 1 - lvl);
            dir  = wsh[0];
            res  = (res & ~(TreeW'(1) << node)) | (TreeW'(!dir) << node);
            node = 2 * node + (dir ? 32'd2 : 32'd1);
        end
        return res;
    endfunction

    assign in_init     = (state_q == ST_INIT);
    assign init_last   = (init_cnt_q == IdxW'(NumSets - 1));
    assign res_valid_o = (state_q == ST_RESP);
    assign req_ready_o = !in_init && (!res_valid_o || res_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign init_busy_o = in_init;

    // Lowest invalid-and-unlocked way, lowest unlocked way, and hit way index
    always_comb begin
        free_idx = '0;
        has_free = 1'b0;
        unl_idx  = '0;
        hit_idx  = '0;
        for (int w = NumWays - 1; w >= 0; w--) begin
            if (!tag_valid_i[w] && !lock_i[w]) begin
                free_idx = WayW'(w);
                has_free = 1'b1;
            end
            if (!lock_i[w]) begin
                unl_idx = WayW'(w);
            end
        end
        for (int w = 0; w < NumWays; w++) begin
            if (req_hit_way_i[w]) begin
                hit_idx = hit_idx | WayW'(w);
            end
        end
    end

    assign all_locked = &lock_i;
    assign miss_way   = has_free ? free_idx : (lock_i[pol_victim] ? unl_idx : pol_victim);
    assign upd_way    = req_hit_i ? hit_idx : miss_way;
    assign sel_noway  = !req_hit_i && all_locked;
    assign sel_way    = req_hit_i ? req_hit_way_i : (all_locked ? '0 : (NumWays'(1) << miss_way));
    assign sel_evict  = !req_hit_i && !all_locked && !has_free && tag_dirty_i[miss_way];

    if (ReplPolicy == 0) begin : g_plru
        logic [TreeW-1:0] tree_q [NumSets];
        logic [TreeW-1:0] tree_rd;
        assign tree_rd    = tree_q[req_index_i];
        assign pol_victim = plru_victim(tree_rd);
        // Sweep-clear during INIT, otherwise retouch the accessed set on hit or allocating miss
        always_ff @(posedge clk_i) begin
            if (in_init) begin
                tree_q[init_cnt_q] <= '0;
            end else if (accept && !sel_noway) begin
                tree_q[req_index_i] <= plru_touch(tree_rd, upd_way);
            end
        end
    end else if (ReplPolicy == 1) begin : g_rand
        logic [15:0] lfsr_q;
        assign pol_victim = lfsr_q[WayW-1:0];
        // Free-running Fibonacci LFSR (taps 16,14,13,11), also clocked during INIT
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lfsr_q <= 16'hACE1;
            end else begin
                lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            end
        end
    end else begin : g_rr
        logic [WayW-1:0] ptr_q [NumSets];
        assign pol_victim = ptr_q[req_index_i];
        // Sweep-clear during INIT, otherwise advance past the way just allocated
        always_ff @(posedge clk_i) begin
            if (in_init) begin
                ptr_q[init_cnt_q] <= '0;
            end else if (accept && !req_hit_i && !sel_noway) begin
                ptr_q[req_index_i] <= upd_way + WayW'(1);
            end
        end
    end

    // Control FSM: init sweep, then idle/response sequencing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + IdxW'(1);
                    if (init_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!accept && res_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Response registers load on accept and hold otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_way_q    <= '0;
            res_evict_q  <= 1'b0;
            res_no_way_q <= 1'b0;
        end else if (accept) begin
            res_way_q    <= sel_way;
            res_evict_q  <= sel_evict;
            res_no_way_q <= sel_noway;
        end
    end

    assign res_way_o    = res_way_q;
    assign res_evict_o  = res_evict_q;
    assign res_no_way_o = res_no_way_q;

`ifdef AXI_LLC_REPL_STATS_EN
    logic        res_hit_q;
    logic        res_hs;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic [31:0] evict_cnt_q;

    assign res_hs = res_valid_o && res_ready_i;

    // Remember whether the held response is a hit so the handshake can be classified
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_hit_q <= 1'b0;
        end else if (accept) begin
            res_hit_q <= req_hit_i;
        end
    end

    // Saturating counters bumped on each response handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            evict_cnt_q <= '0;
        end else if (res_hs) begin
            if (res_hit_q && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!res_hit_q && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (res_evict_q && evict_cnt_q != '1) begin
                evict_cnt_q <= evict_cnt_q + 32'd1;
            end
        end
    end

    assign stat_hit_o   = hit_cnt_q;
    assign stat_miss_o  = miss_cnt_q;
    assign stat_evict_o = evict_cnt_q;
`else
    assign stat_hit_o   = '0;
    assign stat_miss_o  = '0;
    assign stat_evict_o = '0;
`endif

endmodule

// File: tb/tb_axi_llc_repl_unit.sv
// tb/tb_axi_llc_repl_unit.sv - self-checking bench for axi_llc_repl_unit (PLRU, round-robin and random instances)
module tb_axi_llc_repl_unit;

    localparam int NK = 3;
`ifdef AXI_LLC_REPL_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_valid;
    logic [7:0] req_index;
    logic       req_hit;
    logic [7:0] hit_way, tag_valid, tag_dirty, lock;
    logic       res_ready;

    logic        rdy0, rv0, ev0, nw0, busy0;
    logic        rdy1, rv1, ev1, nw1, busy1;
    logic        rdy2, rv2, ev2, nw2, busy2;
    logic [3:0]  way0, way1;
    logic [7:0]  way2;
    logic [31:0] sh0, sm0, se0, sh1, sm1, se1, sh2, sm2, se2;

    axi_llc_repl_unit #(.NumWays(4), .NumSets(256), .ReplPolicy(0)) u_plru (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy0),
        .req_index_i(req_index), .req_hit_i(req_hit), .req_hit_way_i(hit_way[3:0]),
        .tag_valid_i(tag_valid[3:0]), .tag_dirty_i(tag_dirty[3:0]), .lock_i(lock[3:0]),
        .res_valid_o(rv0), .res_ready_i(res_ready), .res_way_o(way0), .res_evict_o(ev0),
        .res_no_way_o(nw0), .init_busy_o(busy0), .stat_hit_o(sh0), .stat_miss_o(sm0), .stat_evict_o(se0));

    axi_llc_repl_unit #(.NumWays(4), .NumSets(8), .ReplPolicy(2)) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1),
        .req_index_i(req_index[2:0]), .req_hit_i(req_hit), .req_hit_way_i(hit_way[3:0]),
        .tag_valid_i(tag_valid[3:0]), .tag_dirty_i(tag_dirty[3:0]), .lock_i(lock[3:0]),
        .res_valid_o(rv1), .res_ready_i(res_ready), .res_way_o(way1), .res_evict_o(ev1),
        .res_no_way_o(nw1), .init_busy_o(busy1), .stat_hit_o(sh1), .stat_miss_o(sm1), .stat_evict_o(se1));

    axi_llc_repl_unit #(.NumWays(8), .NumSets(4), .ReplPolicy(1)) u_rand (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy2),
        .req_index_i(req_index[1:0]), .req_hit_i(req_hit), .req_hit_way_i(hit_way),
        .tag_valid_i(tag_valid), .tag_dirty_i(tag_dirty), .lock_i(lock),
        .res_valid_o(rv2), .res_ready_i(res_ready), .res_way_o(way2), .res_evict_o(ev2),
        .res_no_way_o(nw2), .init_busy_o(busy2), .stat_hit_o(sh2), .stat_miss_o(sm2), .stat_evict_o(se2));

    logic        a_rdy [NK], a_rv [NK], a_ev [NK], a_nw [NK], a_busy [NK];
    logic [7:0]  a_way [NK];
    logic [31:0] a_sh [NK], a_sm [NK], a_se [NK];

    assign a_rdy[0] = rdy0;  assign a_rdy[1] = rdy1;  assign a_rdy[2] = rdy2;
    assign a_rv[0]  = rv0;   assign a_rv[1]  = rv1;   assign a_rv[2]  = rv2;
    assign a_ev[0]  = ev0;   assign a_ev[1]  = ev1;   assign a_ev[2]  = ev2;
    assign a_nw[0]  = nw0;   assign a_nw[1]  = nw1;   assign a_nw[2]  = nw2;
    assign a_busy[0] = busy0; assign a_busy[1] = busy1; assign a_busy[2] = busy2;
    assign a_way[0] = {4'b0, way0}; assign a_way[1] = {4'b0, way1}; assign a_way[2] = way2;
    assign a_sh[0] = sh0; assign a_sh[1] = sh1; assign a_sh[2] = sh2;
    assign a_sm[0] = sm0; assign a_sm[1] = sm1; assign a_sm[2] = sm2;
    assign a_se[0] = se0; assign a_se[1] = se1; assign a_se[2] = se2;

    function automatic int nways(input int k);
        return (k == 2) ? 8 : 4;
    endfunction
    function automatic int nsets(input int k);
        return (k == 0) ? 256 : ((k == 1) ? 8 : 4);
    endfunction
    function automatic int policy(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
    endfunction

    // Reference state
    bit [7:0] m_tree [NK][256];
    int       m_rr   [NK][256];
    int       m_lfsr;
    int       m_init [NK];
    bit       e_valid [NK], e_hit [NK], e_evict [NK], e_noway [NK];
    bit [7:0] e_way [NK];
    int       c_hit [NK], c_miss [NK], c_ev [NK];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t: got 0x%0h, want 0x%0h", nm, k, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input int c);
        return STATS_ON ? 32'(c) : 32'd0;
    endfunction

    // Leaf reached by following the node bits from the root
    function automatic int plru_victim(input bit [7:0] t, input int nw);
        int node = 0;
        while (node < nw - 1) node = t[node] ? 2 * node + 2 : 2 * node + 1;
        return node - (nw - 1);
    endfunction

    // Climb from the leaf, making each ancestor point at the sibling subtree
    function automatic bit [7:0] plru_touch(input bit [7:0] t, input int w, input int nw);
        int leaf = w + nw - 1;
        int parent;
        while (leaf > 0) begin
            parent    = (leaf - 1) / 2;
            t[parent] = (leaf == 2 * parent + 1);
            leaf      = parent;
        end
        return t;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_init[k]  = nsets(k);
            e_valid[k] = 0; e_hit[k] = 0; e_evict[k] = 0; e_noway[k] = 0; e_way[k] = 0;
            c_hit[k] = 0; c_miss[k] = 0; c_ev[k] = 0;
            for (int s = 0; s < 256; s++) begin
                m_tree[k][s] = 0;
                m_rr[k][s]   = 0;
            end
        end
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_accept(input int k);
        int nw = nways(k);
        int s  = req_index % nsets(k);
        int w  = -1;
        int vic;
        bit all_lk = 1;
        e_valid[k] = 1; e_hit[k] = req_hit; e_evict[k] = 0; e_noway[k] = 0;
        for (int i = 0; i < nw; i++) if (!lock[i]) all_lk = 0;
        if (req_hit) begin
            for (int i = 0; i < nw; i++) if (hit_way[i]) w = i;
            e_way[k] = 8'(1 << w);
            if (policy(k) == 0) m_tree[k][s] = plru_touch(m_tree[k][s], w, nw);
        end else if (all_lk) begin
            e_way[k]   = 0;
            e_noway[k] = 1;
        end else begin
            for (int i = nw - 1; i >= 0; i--) if (!tag_valid[i] && !lock[i]) w = i;
            if (w < 0) begin
                case (policy(k))
                    0:       vic = plru_victim(m_tree[k][s], nw);
                    1:       vic = m_lfsr % nw;
                    default: vic = m_rr[k][s];
                endcase
                if (lock[vic]) begin
                    for (int i = nw - 1; i >= 0; i--) if (!lock[i]) vic = i;
                end
                w = vic;
                e_evict[k] = tag_dirty[w];
            end
            e_way[k] = 8'(1 << w);
            if (policy(k) == 0) m_tree[k][s] = plru_touch(m_tree[k][s], w, nw);
            if (policy(k) == 2) m_rr[k][s] = (w + 1) % nw;
        end
    endtask

    // One clock: check ready before the edge, advance the model, check all outputs after the edge
    task automatic step();
        bit acc [NK];
        bit exp_rdy;
        int fb;
        #1;
        for (int k = 0; k < NK; k++) begin
            exp_rdy = (m_init[k] == 0) && (!e_valid[k] || res_ready);
            chk("req_ready", k, 32'(a_rdy[k]), 32'(exp_rdy));
            acc[k] = req_valid && exp_rdy;
        end
        for (int k = 0; k < NK; k++) begin
            if (e_valid[k] && res_ready) begin
                if (e_hit[k]) c_hit[k]++; else c_miss[k]++;
                if (e_evict[k]) c_ev[k]++;
            end
            if (acc[k]) model_accept(k);
            else if (res_ready) e_valid[k] = 0;
            if (m_init[k] > 0) m_init[k]--;
        end
        fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = ((m_lfsr >> 1) | (fb << 15)) & 16'hFFFF;
        @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            chk("init_busy", k, 32'(a_busy[k]), 32'(m_init[k] > 0));
            chk("res_valid", k, 32'(a_rv[k]), 32'(e_valid[k]));
            if (e_valid[k]) begin
                chk("res_way", k, 32'(a_way[k]), 32'(e_way[k]));
                chk("res_evict", k, 32'(a_ev[k]), 32'(e_evict[k]));
                chk("res_no_way", k, 32'(a_nw[k]), 32'(e_noway[k]));
            end
            chk("stat_hit", k, a_sh[k], st(c_hit[k]));
            chk("stat_miss", k, a_sm[k], st(c_miss[k]));
            chk("stat_evict", k, a_se[k], st(c_ev[k]));
        end
    endtask

    task automatic issue(input int idx, input bit hit, input bit [7:0] hw, input bit [7:0] tv,
                         input bit [7:0] td, input bit [7:0] lk);
        req_valid = 1; req_index = 8'(idx); req_hit = hit; hit_way = hw;
        tag_valid = tv; tag_dirty = td; lock = lk; res_ready = 1;
        step();
        req_valid = 0;
    endtask

    task automatic wait_init();
        int cnt = 0;
        while (a_busy[0] && cnt < 400) begin
            cnt++;
            step();
        end
        chk("init_cycles", 0, 32'(cnt), 32'd256);
        chk("ready_after_init", 0, 32'(a_rdy[0]), 32'd1);
    endtask

    initial begin
        int r;
        rst_n = 0; req_valid = 0; req_index = 0; req_hit = 0; hit_way = 0;
        tag_valid = 8'hFF; tag_dirty = 0; lock = 0; res_ready = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            chk("rst_valid", k, 32'(a_rv[k]), 32'd0);
            chk("rst_way", k, 32'(a_way[k]), 32'd0);
            chk("rst_evict", k, 32'(a_ev[k]), 32'd0);
            chk("rst_no_way", k, 32'(a_nw[k]), 32'd0);
            chk("rst_busy", k, 32'(a_busy[k]), 32'd1);
            chk("rst_ready", k, 32'(a_rdy[k]), 32'd0);
            chk("rst_stat_hit", k, a_sh[k], 32'd0);
        end
        rst_n = 1;
        wait_init();

        // PLRU sequence on a fresh set
        issue(5, 0, 0, 8'hFF, 0, 0);  chk("plru_m1", 0, 32'(a_way[0]), 32'h1);
        issue(5, 0, 0, 8'hFF, 0, 0);  chk("plru_m2", 0, 32'(a_way[0]), 32'h4);
        issue(5, 1, 8'h04, 8'hFF, 0, 0); chk("plru_hit", 0, 32'(a_way[0]), 32'h4);
        issue(5, 0, 0, 8'hFF, 0, 0);  chk("plru_m3", 0, 32'(a_way[0]), 32'h2);

        // Invalid way first, dirty victim, lock masking
        issue(6, 0, 0, 8'hFB, 8'hFF, 0);
        chk("free_way", 0, 32'(a_way[0]), 32'h4);
        chk("free_evict", 0, 32'(a_ev[0]), 32'd0);
        issue(7, 0, 0, 8'hFF, 8'hFF, 0);
        chk("dirty_evict", 0, 32'(a_ev[0]), 32'd1);
        issue(9, 0, 0, 8'hFF, 0, 8'hFF);
        chk("all_lock_noway", 0, 32'(a_nw[0]), 32'd1);
        chk("all_lock_way", 0, 32'(a_way[0]), 32'd0);
        issue(8, 0, 0, 8'hFF, 0, 8'h01);
        chk("lock_skip", 0, 32'(a_way[0]), 32'h2);

        // Round-robin walk with wrap
        for (int i = 0; i < 5; i++) begin
            issue(3, 0, 0, 8'hFF, 0, 0);
            chk("rr_seq", 1, 32'(a_way[1]), 32'(1 << (i % 4)));
        end

        // Back-pressure: outputs hold and ready stays low
        issue(3, 0, 0, 8'hFF, 0, 0);
        req_valid = 1; req_index = 8'd4; res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_way", 1, 32'(a_way[1]), 32'h2);
            chk("stall_ready", 1, 32'(a_rdy[1]), 32'd0);
            chk("stall_valid", 1, 32'(a_rv[1]), 32'd1);
        end
        req_valid = 0; res_ready = 1;
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_index = 8'($urandom_range(0, 7));
            req_hit   = ($urandom_range(0, 3) == 0);
            hit_way   = 8'(1 << $urandom_range(0, 3));
            tag_valid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            tag_dirty = 8'($urandom);
            r = $urandom_range(0, 9);
            lock      = (r == 0) ? 8'hFF : ((r < 3) ? (8'($urandom) & 8'($urandom)) : 8'h00);
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset in the middle of a pending response
        issue(1, 0, 0, 8'hFF, 0, 0);
        res_ready = 0;
        rst_n = 0;
        #1;
        chk("async_rst_valid", 0, 32'(a_rv[0]), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1; res_ready = 1;
        wait_init();

        // Statistics: 10 hits then 5 dirty misses
        for (int i = 0; i < 10; i++) issue($urandom_range(0, 7), 1, 8'(1 << $urandom_range(0, 3)), 8'hFF, 8'($urandom), 0);
        for (int i = 0; i < 5; i++) issue($urandom_range(0, 7), 0, 0, 8'hFF, 8'hFF, 0);
        step();
        for (int k = 0; k < NK; k++) begin
            chk("stats_hit10", k, a_sh[k], STATS_ON ? 32'd10 : 32'd0);
            chk("stats_miss5", k, a_sm[k], STATS_ON ? 32'd5 : 32'd0);
            chk("stats_evict5", k, a_se[k], STATS_ON ? 32'd5 : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_llc_repl_unit.md
# axi_llc_repl_unit

Parametrised replacement unit for the LLC hit/miss detection stage; the successor to the single-policy eviction box. It keeps per-set replacement state for `NumSets` sets of `NumWays` ways and selects a policy at elaboration time: tree-PLRU, LFSR-random or per-set round-robin. On each request it returns a registered one-hot way, an evict (write-back) flag and a no-way flag through a valid/ready handshake. It masks locked (SPM) ways and clears all state after reset with an init sweep.

## Interface
- `NumWays`, 8: set associativity; power of two, ≥ 2.
- `NumSets`, 256: sets with stored state; ≥ 2.
- `ReplPolicy`, 0: 0 = tree-PLRU, 1 = LFSR random, 2 = round-robin; other values are an elaboration error.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous reset, active low.
- `req_valid_i` in 1, `req_ready_o` out 1: request handshake.
- `req_index_i` in $clog2(NumSets): set index.
- `req_hit_i` in 1: lookup hit.
- `req_hit_way_i` in NumWays: one-hot hit way, valid when `req_hit_i` is 1.
- `tag_valid_i`, `tag_dirty_i`, `lock_i` in NumWays each: per-way valid, dirty and locked flags.
- `res_valid_o` out 1, `res_ready_i` in 1: response handshake.
- `res_way_o` out NumWays: one-hot selected way; onehot0.
- `res_evict_o` out 1: the selected line is dirty and must be written back.
- `res_no_way_o` out 1: every way is locked.
- `init_busy_o` out 1: init sweep in progress.
- `stat_hit_o`, `stat_miss_o`, `stat_evict_o` out 32 each: statistics counters (see Configuration).

## Operation
- FSM states: INIT, IDLE, RESP. Reset enters INIT.
- INIT: a set counter clears one set's state per cycle (PLRU bits = 0, RR pointer = 0). After `NumSets` cycles the FSM goes to IDLE.
- `req_ready_o` = !INIT && (!`res_valid_o` || `res_ready_i`). A request is accepted on `req_valid_i && req_ready_o`.
- On accept, the response registers load and the set state updates in the same edge. The FSM enters RESP, or stays in RESP on a back-to-back accept.
- In RESP with `res_ready_i` and no new accept, the FSM returns to IDLE.
- Hit: `res_way_o` = `req_hit_way_i`, evict = 0.
  - PLRU: path bits point away from the hit way.
  - RR and random: no state change.
- Miss, candidate selection:
  - If any way has `!tag_valid_i && !lock_i`, pick the lowest such index, evict = 0.
  - Otherwise take the policy victim. If that victim is locked, use the lowest-index unlocked way.
  - Evict = `tag_dirty_i` of the chosen way.
- Miss, state update:
  - PLRU: path bits point away from the chosen way.
  - RR: pointer = chosen + 1 mod NumWays.
- All ways locked on a miss: `res_way_o` = 0, `res_no_way_o` = 1, evict = 0, no state update.
- Tree-PLRU encoding:
  - NumWays−1 bits per set; node i has children 2i+1 and 2i+2.
  - Bit 0 = go to the lower-index subtree. The victim walk follows the bits from the root.
- Random policy:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset. It advances every cycle, including INIT.
  - Victim = LFSR[$clog2(NumWays)-1:0].
- Back-to-back requests to the same set see the state written by the previous accept.

## Timing
- Reset values:
  - `res_valid_o`, `res_way_o`, `res_evict_o`, `res_no_way_o` = 0.
  - `init_busy_o` = 1 and `req_ready_o` = 0 during INIT.
  - Statistics counters = 0.
- Latency: accept at edge N gives `res_valid_o` high after edge N. Throughput is one request per cycle while `res_ready_i` stays high.
- Response outputs hold stable while `res_valid_o && !res_ready_i`.
- `req_*` and `tag_*` are sampled only at accept.
- The first accept is possible at cycle `NumSets` after reset release.
- A reset assertion mid-operation drops `res_valid_o` asynchronously and restarts INIT.

## Configuration
- `AXI_LLC_REPL_STATS_EN` defined:
  - Saturating 32-bit counters increment on each response handshake (`res_valid_o && res_ready_i`).
  - hit: the response was a hit.
  - miss: the response was a miss.
  - evict: `res_evict_o` was 1.
- `AXI_LLC_REPL_STATS_EN` not defined: the counter logic is removed and `stat_*_o` are tied to 0.

## Test plan
- Reset with NumSets=256: `init_busy_o` high and `req_ready_o` low for exactly 256 cycles, then ready = 1.
- PLRU with NumWays=4, all valid, clean, unlocked: misses to set 5 return way 0001, then 0100, then 0010. A hit on way 0100, followed by a miss, returns 0010.
- Miss with `tag_valid_i`=4'b1011 → way 0100, evict 0. All valid with `tag_dirty_i`=4'b1111 → evict 1.
- `lock_i`=4'b1111 on a miss → `res_no_way_o`=1, `res_way_o`=0. `lock_i`=4'b0001 with PLRU victim way 0 → way 0010.
- RR policy: four misses to set 3 return ways 0,1,2,3 then wrap to 0. Holding `res_ready_i` low for 3 cycles keeps the outputs stable and `req_ready_o` low.
- With `AXI_LLC_REPL_STATS_EN`: 10 hits and 5 dirty misses → `stat_hit_o`=10, `stat_miss_o`=5, `stat_evict_o`=5. Without the macro, all three read 0.
